mmio_button_in: RTL and testbench

- Memory-mapped input peripheral: the input-side counterpart of the core's LED output register.
- Samples asynchronous board buttons, synchronises and debounces them, and latches press events.
- The PipelinedCore load path reads the results through a small register window with 1-cycle read latency.
- Replaces the unused raw `btn` input on the core top level.

---
 rtl/mmio_button_in.sv | 128 ++++++++++++
 tb/tb_mmio_button_in.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_button_in.sv
// Memory-mapped button input: 2-flop sync, per-bit debounce, sticky press events, press counter.
// Optional macro BTN_IRQ_EN adds a maskable level interrupt and a mask write port.
module mmio_button_in #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic               original_clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn,
   input  logic               rd_en,
   input  logic [1:0]         rd_addr,
`ifdef BTN_IRQ_EN
   input  logic               wr_en,
   input  logic [31:0]        wr_data,
`endif
   output logic [31:0]        rd_data,
   output logic               rd_valid,
   output logic               irq
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_BTN-1:0] sync1_q, sync1_d;
   logic [NUM_BTN-1:0] sync2_q, sync2_d;
   logic [NUM_BTN-1:0] db_q, db_d;
   logic [NUM_BTN-1:0] db_dly_q, db_dly_d;
   logic [CNT_W-1:0]   cnt_q [NUM_BTN];
   logic [CNT_W-1:0]   cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] ev_q, ev_d;
   logic [15:0]        pc_q, pc_d;
   logic [31:0]        rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic               irq_q, irq_d;
   logic [NUM_BTN-1:0] rise;
   logic [31:0]        reg_sel;
`ifdef BTN_IRQ_EN
   logic [NUM_BTN-1:0] mask_q, mask_d;
`endif

   function automatic logic [15:0] popcount(input logic [NUM_BTN-1:0] v);
      logic [15:0] n;
      n = '0;
      for (int i = 0; i < NUM_BTN; i++) n = n + 16'(v[i]);
      return n;
   endfunction

   always_comb begin
      sync1_d  = btn;
      sync2_d  = sync1_q;
      db_d     = db_q;
      db_dly_d = db_q;
      // Counter only runs while the synchronised input disagrees with the debounced level.
      for (int i = 0; i < NUM_BTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CNT_LAST) db_d[i] = sync2_q[i];
            else                      cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end

      rise    = db_q & ~db_dly_q;
      reg_sel = '0;
      case (rd_addr)
         2'd0:    reg_sel[NUM_BTN-1:0] = db_q;
         2'd1:    reg_sel[NUM_BTN-1:0] = ev_q;
         2'd2:    reg_sel[15:0]        = pc_q;
         default: begin
`ifdef BTN_IRQ_EN
            reg_sel[NUM_BTN-1:0] = mask_q;
`endif
         end
      endcase

      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? reg_sel : rd_data_q;

      // Clear-on-read drops every captured event but keeps a same-cycle rise.
      ev_d = ev_q | rise;
      if (rd_en && rd_addr == 2'd1) ev_d = rise;
      pc_d = pc_q + popcount(rise);

`ifdef BTN_IRQ_EN
      mask_d = mask_q;
      if (wr_en && rd_addr == 2'd3) mask_d = wr_data[NUM_BTN-1:0];
      irq_d = |(ev_d & mask_d);
`else
      irq_d = 1'b0;
`endif
   end

   always_ff @(posedge original_clk) begin
      if (!rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_q       <= '0;
         db_dly_q   <= '0;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
         ev_q       <= '0;
         pc_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
`ifdef BTN_IRQ_EN
         mask_q     <= '1;
`endif
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_q       <= db_d;
         db_dly_q   <= db_dly_d;
         for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
         ev_q       <= ev_d;
         pc_q       <= pc_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         irq_q      <= irq_d;
`ifdef BTN_IRQ_EN
         mask_q     <= mask_d;
`endif
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_button_in.sv
// Bench for mmio_button_in: directed test-plan steps plus random stimulus against a window-based model.
module tb_mmio_button_in;
   localparam int NB = 4;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB-1:0] btn;
   logic          rd_en;
   logic [1:0]    rd_addr;
   logic [31:0]   rd_data;
   logic          rd_valid;
   logic          irq;

   logic [NB-1:0] btn_w;
   logic          rd_en_w;
   logic [1:0]    rd_addr_w;
   logic [31:0]   rd_data_w;
   logic          rd_valid_w;
   logic          irq_w;
`ifdef BTN_IRQ_EN
   logic          wr_en = 1'b0;
   logic [31:0]   wr_data = '0;
`endif

   always #5 clk = ~clk;

   mmio_button_in #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
      .original_clk(clk), .rst(rst), .btn(btn), .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef BTN_IRQ_EN
      .wr_en(wr_en), .wr_data(wr_data),
`endif
      .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq));

   // Short debounce instance so a full 16-bit press-count wrap fits in the run.
   mmio_button_in #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(2), .CNT_W(16)) dut_w (
      .original_clk(clk), .rst(rst), .btn(btn_w), .rd_en(rd_en_w), .rd_addr(rd_addr_w),
`ifdef BTN_IRQ_EN
      .wr_en(wr_en), .wr_data(wr_data),
`endif
      .rd_data(rd_data_w), .rd_valid(rd_valid_w), .irq(irq_w));

   int checks = 0;
   int errors = 0;

   // Reference model: the debounced level follows s once the last D samples all disagree with it.
   logic [NB-1:0] m_s1, m_s, m_db, m_dbd, m_ev;
   logic [15:0]   m_pc;
   logic [31:0]   m_data;
   logic          m_valid;
   logic [NB-1:0] hist[$];

   always @(posedge clk) begin
      logic [NB-1:0] s_used, nd, rs;
      logic          all_diff;
      if (!rst) begin
         m_s1 = '0; m_s = '0; m_db = '0; m_dbd = '0; m_ev = '0;
         m_pc = '0; m_data = '0; m_valid = 1'b0;
         hist.delete();
      end else begin
         s_used = m_s;
         m_s    = m_s1;
         m_s1   = btn;
         hist.push_back(s_used);
         if (hist.size() > D) void'(hist.pop_front());
         nd = m_db;
         if (hist.size() == D) begin
            for (int i = 0; i < NB; i++) begin
               all_diff = 1'b1;
               for (int j = 0; j < D; j++) if (hist[j][i] == m_db[i]) all_diff = 1'b0;
               if (all_diff) nd[i] = ~m_db[i];
            end
         end
         rs = m_db & ~m_dbd;
         m_valid = rd_en;
         if (rd_en) begin
            case (rd_addr)
               2'd0:    m_data = {28'h0, m_db};
               2'd1:    m_data = {28'h0, m_ev};
               2'd2:    m_data = {16'h0, m_pc};
               default: m_data = 32'h0;
            endcase
         end
         if (rd_en && rd_addr == 2'd1) m_ev = rs;
         else                          m_ev = m_ev | rs;
         m_pc  = m_pc + 16'($countones(rs));
         m_dbd = m_db;
         m_db  = nd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("rd_valid", {31'h0, rd_valid}, {31'h0, m_valid});
      chk("rd_data", rd_data, m_data);
      chk("irq", {31'h0, irq}, 32'h0);
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      rd_en   = 1'b1;
      rd_addr = a;
      step();
      d     = rd_data;
      rd_en = 1'b0;
   endtask

   task automatic rd_w(input logic [1:0] a, output logic [31:0] d);
      rd_en_w   = 1'b1;
      rd_addr_w = a;
      @(negedge clk);
      chk("wrap_valid", {31'h0, rd_valid_w}, 32'h1);
      d       = rd_data_w;
      rd_en_w = 1'b0;
   endtask

   initial begin
      logic [31:0] d, d1, d2;
      int b;
      rst = 1'b0; btn = '0; rd_en = 1'b0; rd_addr = '0;
      btn_w = '0; rd_en_w = 1'b0; rd_addr_w = '0;

      // Reset held with buttons pressed
      btn = 4'hF;
      repeat (5) step();
      chk("rst_data", rd_data, 32'h0);
      chk("rst_valid", {31'h0, rd_valid}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      rst = 1'b1;
      for (int k = 0; k < 10; k++) begin
         rd(2'd0, d);
         chk("rst_release_db", d, (k >= 2 + D) ? 32'hF : 32'h0);
      end
      btn = '0;
      repeat (10) step();
      rd(2'd1, d);
      chk("rst_release_ev", d, 32'hF);

      // Fresh start for the debounce sequence
      rst = 1'b0;
      step();
      rst = 1'b1;
      btn = 4'h1;
      repeat (3) step();
      btn = 4'h0;
      repeat (8) step();
      rd(2'd0, d);
      chk("glitch_db", d, 32'h0);
      rd(2'd2, d);
      chk("glitch_pc", d, 32'h0);
      btn = 4'h1;
      for (int k = 0; k < 10; k++) begin
         rd(2'd0, d);
         chk("hold_db", d, (k >= 6) ? 32'h1 : 32'h0);
      end
      rd(2'd2, d);
      chk("hold_pc", d, 32'h1);
      btn = 4'h0;
      repeat (10) step();

      // Clear-on-read, back-to-back
      rd(2'd1, d);
      chk("ev_pre_clear", d, 32'h1);
      btn = 4'h2;
      repeat (10) step();
      btn = 4'h0;
      repeat (10) step();
      rd_en = 1'b1; rd_addr = 2'd1;
      step();
      d1 = rd_data;
      chk("cor_valid1", {31'h0, rd_valid}, 32'h1);
      step();
      d2 = rd_data;
      chk("cor_valid2", {31'h0, rd_valid}, 32'h1);
      rd_en = 1'b0;
      step();
      chk("cor_first", d1, 32'h2);
      chk("cor_second", d2, 32'h0);
      chk("cor_valid_drop", {31'h0, rd_valid}, 32'h0);
      chk("cor_hold", rd_data, 32'h0);

      // Rise coinciding with a clearing read
      btn = 4'h4;
      repeat (6) step();
      rd(2'd1, d);
      chk("sim_same", d, 32'h0);
      rd(2'd1, d);
      chk("sim_next", d, 32'h4);
      btn = 4'h0;
      repeat (10) step();
      rd(2'd2, d);
      chk("pc_before_pair", d, 32'h3);
      btn = 4'h9;
      repeat (10) step();
      btn = 4'h0;
      repeat (10) step();
      rd(2'd2, d);
      chk("pc_pair", d, 32'h5);
      rd(2'd3, d);
      chk("reserved", d, 32'h0);

      // Random buttons, reads and one mid-run reset, checked every cycle
      for (int c = 0; c < 2500; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            b = int'($urandom_range(0, NB - 1));
            btn[b] = ~btn[b];
         end
         rd_en   = ($urandom_range(0, 1) == 1);
         rd_addr = 2'($urandom_range(0, 3));
         rst     = (c == 1200) ? 1'b0 : 1'b1;
         step();
      end
      rd_en = 1'b0; rst = 1'b1; btn = '0;
      repeat (12) step();

      // Press-counter wrap on the short-debounce instance
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int p = 0; p < 16383; p++) begin
         btn_w = 4'hF;
         repeat (2) @(negedge clk);
         btn_w = 4'h0;
         repeat (2) @(negedge clk);
      end
      for (int p = 0; p < 3; p++) begin
         btn_w = 4'h1;
         repeat (2) @(negedge clk);
         btn_w = 4'h0;
         repeat (2) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      rd_w(2'd2, d);
      chk("wrap_ffff", d, 32'h0000_FFFF);
      btn_w = 4'h1;
      repeat (2) @(negedge clk);
      btn_w = 4'h0;
      repeat (8) @(negedge clk);
      rd_w(2'd2, d);
      chk("wrap_zero", d, 32'h0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
